led_uart_reporter: RTL and testbench

Downstream consumer of the blink stage's 8-bit `leds` bus. It watches the LED pattern and sends each new value to the remote host as one UART 8N1 byte (LSB first), so the board state can be mirrored remotely. A one-entry pending buffer absorbs changes that arrive mid-frame; the latest value wins. A `send_req` pulse forces a re-send of the current pattern.

---
 rtl/led_uart_reporter_if.sv | 12 +
 rtl/led_uart_reporter.sv | 139 +++++++++++++
 tb/tb_led_uart_reporter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/led_uart_reporter_if.sv
// LED reporter handshake bundle: pattern/request in, serial line and status out.
// master drives the LED pattern and re-send request; slave is the reporter itself.
interface led_uart_reporter_if;
  logic [7:0] leds_in;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       overrun;

  modport master (output leds_in, send_req, input tx, busy, overrun);
  modport slave  (input leds_in, send_req, output tx, busy, overrun);
endinterface

// File: rtl/led_uart_reporter.sv
// Sends each new LED pattern as one UART 8N1 byte; start bit 2 edges after a change, 10 bit-times per frame.
// No backpressure: a one-entry pending buffer keeps the latest value and flags overwrites on overrun.
module led_uart_reporter #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                clk,
  input  logic                rst_n,
  led_uart_reporter_if.slave  bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    last_seen_q, last_seen_d;
  logic [7:0]    pending_dat_q, pending_dat_d;
  logic          pending_vld_q, pending_vld_d;
  logic          tx_q, tx_d;
  logic          overrun_q, overrun_d;

  logic evt;
  logic load;
  logic baud_done;

  assign evt       = (bus.leds_in != last_seen_q) || bus.send_req;
  assign load      = (state_q == ST_IDLE) && pending_vld_q;
  assign baud_done = (baud_q == BAUD_LAST);

  // A new event on the load edge refills the buffer, so it is not an overwrite.
  always_comb begin
    last_seen_d   = bus.leds_in;
    pending_dat_d = pending_dat_q;
    pending_vld_d = pending_vld_q;
    overrun_d     = 1'b0;
    if (evt) begin
      pending_dat_d = bus.leds_in;
      pending_vld_d = 1'b1;
      overrun_d     = pending_vld_q && !load;
    end else if (load) begin
      pending_vld_d = 1'b0;
    end
  end

  // tx_d is the line level for the state being entered, keeping tx purely registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          shift_d = pending_dat_q;
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      baud_q        <= '0;
      bit_q         <= 3'd0;
      shift_q       <= 8'h00;
      last_seen_q   <= 8'h00;
      pending_dat_q <= 8'h00;
      pending_vld_q <= 1'b0;
      tx_q          <= 1'b1;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      last_seen_q   <= last_seen_d;
      pending_dat_q <= pending_dat_d;
      pending_vld_q <= pending_vld_d;
      tx_q          <= tx_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q != ST_IDLE) || pending_vld_q;
endmodule

// File: tb/tb_led_uart_reporter.sv
// Bench for led_uart_reporter: scoreboard of expected bytes checked by a UART receiver on tx.
module tb_led_uart_reporter;
  logic clk;
  logic rst_n;
  led_uart_reporter_if u_if ();

  led_uart_reporter #(.CLK_FREQ(40), .BAUD_RATE(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int frame_cnt = 0;
  int ov_cnt   = 0;
  int last_end = -100;
  logic [7:0] sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (u_if.overrun === 1'b1) ov_cnt <= ov_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tx_low(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (u_if.tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (u_if.busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Receiver: a start is a 1->0 transition at a negedge; each bit must hold for 4 samples.
  logic [9:0] fr_bits;
  logic       fr_v, fr_bad, fr_abort, tx_prev;
  logic [7:0] fr_exp;
  initial begin : uart_mon
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev && !u_if.tx) begin
        frame_cnt++;
        check("gap", 32'(cyc - last_end >= 2), 1);
        fr_bad   = 1'b0;
        fr_abort = 1'b0;
        fr_v     = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < 4; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (!rst_n) fr_abort = 1'b1;
            if (s == 0) fr_v = u_if.tx;
            else if (u_if.tx !== fr_v) fr_bad = 1'b1;
            if (s == 3) fr_bits[b] = fr_v;
          end
        end
        last_end = cyc;
        if (!fr_abort) begin
          check("bit_width", fr_bad, 0);
          check("stop_bit", fr_bits[9], 1);
          check("frame_expected", 32'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            fr_exp = sb_q.pop_front();
            check("frame_data", fr_bits[8:1], fr_exp);
          end
        end
      end
      tx_prev = u_if.tx;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  int   c0, f0, ov0;
  logic ok;
  initial begin : stim
    rst_n = 1'b0;
    u_if.leds_in  = 8'h00;
    u_if.send_req = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx", u_if.tx, 1);
    check("rst_busy", u_if.busy, 0);
    check("rst_overrun", u_if.overrun, 0);
    @(negedge clk) rst_n = 1'b1;
    f0 = frame_cnt;
    repeat (100) @(negedge clk);
    check("idle_no_frame", frame_cnt, f0);
    check("idle_tx", u_if.tx, 1);
    check("idle_busy", u_if.busy, 0);

    // Single change: latency, busy rise and fall.
    @(negedge clk);
    u_if.leds_in = 8'h7F;
    sb_q.push_back(8'h7F);
    c0 = cyc;
    @(negedge clk);
    check("busy_rise", u_if.busy, 1);
    check("tx_before_start", u_if.tx, 1);
    wait_tx_low(20, ok);
    check("start_seen", ok, 1);
    check("start_latency", cyc - c0, 2);
    repeat (39) @(negedge clk);
    check("busy_end_frame", u_if.busy, 1);
    @(negedge clk);
    check("busy_fall", u_if.busy, 0);

    // Mid-frame changes: 0x00 then 0x55, only 0x55 sent, one overrun.
    repeat (5) @(negedge clk);
    ov0 = ov_cnt;
    u_if.send_req = 1'b1;
    sb_q.push_back(8'h7F);
    @(negedge clk) u_if.send_req = 1'b0;
    wait_tx_low(20, ok);
    check("resend_start", ok, 1);
    repeat (8) @(negedge clk);
    u_if.leds_in = 8'h00;
    repeat (8) @(negedge clk);
    u_if.leds_in = 8'h55;
    sb_q.push_back(8'h55);
    wait_idle(300, ok);
    check("midframe_idle", ok, 1);
    check("midframe_overrun", ov_cnt - ov0, 1);
    check("midframe_sb_empty", sb_q.size(), 0);

    // Forced re-send of a stable pattern.
    repeat (5) @(negedge clk);
    ov0 = ov_cnt;
    f0  = frame_cnt;
    u_if.send_req = 1'b1;
    sb_q.push_back(8'h55);
    @(negedge clk) u_if.send_req = 1'b0;
    wait_idle(200, ok);
    check("sendreq_idle", ok, 1);
    check("sendreq_frames", frame_cnt - f0, 1);
    check("sendreq_overrun", ov_cnt - ov0, 0);
    check("sendreq_sb_empty", sb_q.size(), 0);

    // Event on the load edge: old byte first, new byte next, no overrun.
    repeat (5) @(negedge clk);
    ov0 = ov_cnt;
    u_if.leds_in = 8'h3C;
    sb_q.push_back(8'h3C);
    @(negedge clk);
    u_if.leds_in = 8'hA5;
    sb_q.push_back(8'hA5);
    wait_idle(300, ok);
    check("simul_idle", ok, 1);
    check("simul_overrun", ov_cnt - ov0, 0);
    check("simul_sb_empty", sb_q.size(), 0);

    // Asynchronous reset in the middle of a frame.
    repeat (5) @(negedge clk);
    u_if.leds_in = 8'h0F;
    sb_q.push_back(8'h0F);
    wait_tx_low(20, ok);
    check("abort_start", ok, 1);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx_async", u_if.tx, 1);
    check("abort_busy", u_if.busy, 0);
    sb_q.delete();
    u_if.leds_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_pending", u_if.busy, 0);
    f0 = frame_cnt;
    repeat (100) @(negedge clk);
    check("abort_no_frame", frame_cnt, f0);
    check("abort_tx_idle", u_if.tx, 1);

    check("sb_final", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
